sa_skew_feeder: RTL and testbench

- Parametrised input skew feeder for the output-stationary systolic array.
- Accepts one x row-vector (S lanes) and one w column-vector (C lanes) per array step through a valid/ready handshake.
- Delays lane i by i array steps, giving the triangular wavefront the array needs.
- Adds a per-run reduction length, bubble-to-zero insertion, an automatic zero drain, a no-skew bypass mode and a done pulse, so the array controller only starts a run and waits for done.

---
 rtl/sa_skew_feeder.sv | 140 ++++++++++++++
 tb/tb_sa_skew_feeder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sa_skew_feeder.sv
// Input skew feeder for an output-stationary systolic array: lane i is delayed
// by i array steps, with per-run length, zero drain, bypass mode and done pulse.

module sa_skew_lane #(
  parameter int D_W   = 16,
  parameter int DEPTH = 1
) (
  input  logic           I_CLK,
  input  logic           I_RST,
  input  logic           clr_i,
  input  logic           shift_i,
  input  logic           bypass_i,
  input  logic [D_W-1:0] inj_i,
  output logic [D_W-1:0] out_o
);
  logic [DEPTH-1:0][D_W-1:0] chain_q;

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) chain_q <= '0;
    else if (clr_i) chain_q <= '0;
    else if (shift_i) begin
      // bypass keeps the chain flushing zeros so a later skewed run starts clean
      chain_q[0] <= bypass_i ? '0 : inj_i;
      for (int d = 1; d < DEPTH; d++) chain_q[d] <= chain_q[d-1];
    end
  end

  assign out_o = bypass_i ? inj_i : chain_q[DEPTH-1];
endmodule

module sa_skew_feeder #(
  parameter int D_W   = 16,
  parameter int S     = 16,
  parameter int C     = 16,
  parameter int K_MAX = 256,
  parameter int CNT_W = $clog2(K_MAX+1)
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_START,
  input  logic [CNT_W-1:0] I_K_LEN,
  input  logic             I_BYPASS,
  input  logic             I_PE_SHIFT,
  input  logic             I_VLD,
  output logic             O_RDY,
  input  logic [S*D_W-1:0] I_X,
  input  logic [C*D_W-1:0] I_W,
  output logic [S*D_W-1:0] O_X,
  output logic [C*D_W-1:0] O_W,
  output logic             O_FEED_VLD,
  output logic             O_BUSY,
  output logic             O_DONE
);
  localparam int L_MAX = (S > C) ? S : C;
  localparam int D_CW  = (L_MAX > 1) ? $clog2(L_MAX) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] k_len_q, k_cnt_q, k_cnt_d, k_len_sat;
  logic [D_CW-1:0]  d_cnt_q;
  logic             bypass_q, busy_q;
  logic             start_ok, accept, shift_run;

  assign O_RDY      = (state_q == LOAD);
  assign accept     = I_PE_SHIFT & I_VLD & O_RDY;
  assign shift_run  = I_PE_SHIFT & ((state_q == LOAD) | (state_q == DRAIN));
  assign start_ok   = I_START & (state_q == IDLE);
  assign k_len_sat  = (I_K_LEN > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : I_K_LEN;
  assign k_cnt_d    = k_cnt_q + CNT_W'(1);
  assign O_FEED_VLD = shift_run;
  assign O_BUSY     = busy_q;
  assign O_DONE     = (state_q == DONE);

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q  <= IDLE;
      k_len_q  <= '0;
      k_cnt_q  <= '0;
      d_cnt_q  <= '0;
      bypass_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (I_START) begin
          k_len_q  <= k_len_sat;
          bypass_q <= I_BYPASS;
          k_cnt_q  <= '0;
          d_cnt_q  <= '0;
          busy_q   <= 1'b1;
          state_q  <= (k_len_sat == '0) ? DONE : LOAD;
        end
        LOAD: if (accept) begin
          k_cnt_q <= k_cnt_d;
          if (k_cnt_d == k_len_q)
            state_q <= (bypass_q || L_MAX == 1) ? DONE : DRAIN;
        end
        // deepest lane needs L_MAX-1 zero steps to push its last vector out
        DRAIN: if (I_PE_SHIFT) begin
          d_cnt_q <= d_cnt_q + D_CW'(1);
          if (d_cnt_q == D_CW'(L_MAX-2)) state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [S-1:0][D_W-1:0] x_inj, x_out;
  logic [C-1:0][D_W-1:0] w_inj, w_out;

  generate
    for (genvar i = 0; i < S; i++) begin : g_x
      assign x_inj[i] = accept ? I_X[i*D_W +: D_W] : '0;
      if (i == 0) begin : g_l0
        assign x_out[i] = x_inj[i];
      end else begin : g_ln
        sa_skew_lane #(.D_W(D_W), .DEPTH(i)) u_lane (
          .I_CLK, .I_RST, .clr_i(start_ok), .shift_i(shift_run),
          .bypass_i(bypass_q), .inj_i(x_inj[i]), .out_o(x_out[i]));
      end
    end
    for (genvar j = 0; j < C; j++) begin : g_w
      assign w_inj[j] = accept ? I_W[j*D_W +: D_W] : '0;
      if (j == 0) begin : g_l0
        assign w_out[j] = w_inj[j];
      end else begin : g_ln
        sa_skew_lane #(.D_W(D_W), .DEPTH(j)) u_lane (
          .I_CLK, .I_RST, .clr_i(start_ok), .shift_i(shift_run),
          .bypass_i(bypass_q), .inj_i(w_inj[j]), .out_o(w_out[j]));
      end
    end
  endgenerate

  assign O_X = x_out;
  assign O_W = w_out;
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder (S=C=4): per-cycle compare against a wavefront
// model built from injection history, plus hand-computed run expectations.

module tb_sa_skew_feeder;
  localparam int D_W = 16, S = 4, C = 4, K_MAX = 256, CNT_W = 9, MAXL = 4;

  logic             clk = 1'b0;
  logic             rst, start, bypass, shift, vld;
  logic [CNT_W-1:0] k_len;
  logic [S*D_W-1:0] x, ox;
  logic [C*D_W-1:0] w, ow;
  logic             rdy, fv, busy, done;

  sa_skew_feeder #(.D_W(D_W), .S(S), .C(C), .K_MAX(K_MAX), .CNT_W(CNT_W)) dut (
    .I_CLK(clk), .I_RST(rst), .I_START(start), .I_K_LEN(k_len), .I_BYPASS(bypass),
    .I_PE_SHIFT(shift), .I_VLD(vld), .O_RDY(rdy), .I_X(x), .I_W(w), .O_X(ox), .O_W(ow),
    .O_FEED_VLD(fv), .O_BUSY(busy), .O_DONE(done));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, fed_total = 0, done_total = 0, rdy_total = 0, dacc_total = 0;
  int start_cyc = 0, done_cyc = 0, last_fv_cyc = 0;
  int q_l0[$], q_l2[$], q_l3[$];
  bit m_active = 0, m_done = 0, m_byp = 0;
  int m_klen = 0, m_acc = 0, m_post = 0, m_drain = 0;
  logic [S-1:0][D_W-1:0] hx[$];
  logic [C-1:0][D_W-1:0] hw[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input int q[$], input int idx, input int e);
    if (idx < q.size()) chk(nm, 64'(q[idx]), 64'(e));
    else begin
      n_chk++; n_err++;
      $display("FAIL %s: no strobe recorded at index %0d, expected %0d", nm, idx, e);
    end
  endtask

  // Model: a run accepts K vectors, then needs (bypass ? 0 : MAXL-1) more strobes;
  // lane i on strobe n shows the vector injected on strobe n-i (n in bypass).
  task automatic monitor();
    logic [S-1:0][D_W-1:0] ix, ax;
    logic [C-1:0][D_W-1:0] iw, aw;
    logic [D_W-1:0] e;
    bit e_rdy, e_fv, e_busy, fin;
    int n;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst O_X", ox, 0); chk("rst O_W", ow, 0); chk("rst O_RDY", 64'(rdy), 0);
        chk("rst O_FEED_VLD", 64'(fv), 0); chk("rst O_BUSY", 64'(busy), 0);
        chk("rst O_DONE", 64'(done), 0);
        m_active = 0; m_done = 0;
      end else begin
        e_rdy  = m_active && (m_acc < m_klen);
        e_fv   = m_active && shift;
        e_busy = m_active || m_done;
        chk("O_RDY", 64'(rdy), 64'(e_rdy));
        chk("O_FEED_VLD", 64'(fv), 64'(e_fv));
        chk("O_BUSY", 64'(busy), 64'(e_busy));
        chk("O_DONE", 64'(done), 64'(m_done));
        rdy_total += int'(rdy);
        if (done) begin done_total++; done_cyc = cyc; end
        fin = 0;
        if (e_fv) begin
          ix = (e_rdy && vld) ? x : '0;
          iw = (e_rdy && vld) ? w : '0;
          hx.push_back(ix); hw.push_back(iw);
          n = hx.size() - 1;
          ax = ox; aw = ow;
          for (int i = 0; i < S; i++) begin
            e = m_byp ? hx[n][i] : ((n >= i) ? hx[n-i][i] : '0);
            chk($sformatf("O_X lane %0d strobe %0d", i, n), 64'(ax[i]), 64'(e));
          end
          for (int j = 0; j < C; j++) begin
            e = m_byp ? hw[n][j] : ((n >= j) ? hw[n-j][j] : '0);
            chk($sformatf("O_W lane %0d strobe %0d", j, n), 64'(aw[j]), 64'(e));
          end
          q_l0.push_back(int'(ax[0])); q_l2.push_back(int'(ax[2])); q_l3.push_back(int'(ax[3]));
          fed_total++; last_fv_cyc = cyc;
          if (fv && rdy && vld) dacc_total++;
          if (e_rdy && vld) m_acc++;
          else if (m_acc == m_klen) m_post++;
          if (m_acc == m_klen && m_post == m_drain) begin m_active = 0; fin = 1; end
        end
        if (!e_busy && start) begin
          m_klen = (int'(k_len) > K_MAX) ? K_MAX : int'(k_len);
          m_byp = bypass; m_acc = 0; m_post = 0;
          m_drain = bypass ? 0 : MAXL - 1;
          hx.delete(); hw.delete(); start_cyc = cyc;
          if (m_klen == 0) fin = 1; else m_active = 1;
        end
        m_done = fin;
      end
    end
  endtask

  task automatic drive(input int v);
    for (int i = 0; i < S; i++) x[i*D_W +: D_W] = 16'(16*v + i);
    for (int j = 0; j < C; j++) w[j*D_W +: D_W] = 16'(4096 + 16*v + j);
  endtask

  task automatic run(input int klen, input bit byp, input int bubble, input int restart_st,
                     input int per);
    int c, st, db;
    db = done_total;
    @(posedge clk); #1;
    start = 1; k_len = CNT_W'(klen); bypass = byp; shift = 0; vld = 1; drive(0);
    @(posedge clk); #1;
    start = 0; c = 0; st = 0;
    while (done_total == db && c < 2000) begin
      shift = (c % per == per - 1);
      vld = !(shift && st == bubble);
      start = shift && st == restart_st;
      if (start) k_len = 7;
      drive(m_acc);
      @(posedge clk); #1;
      if (shift) st++;
      c++;
    end
    start = 0; shift = 0; vld = 1;
    if (done_total == db) begin
      n_chk++; n_err++;
      $display("FAIL run timeout: no O_DONE within 2000 cycles (K_LEN=%0d)", klen);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int fb, db, rb, ab;
    int e1[6] = '{0, 0, 2, 18, 34, 0};
    int e2[4] = '{0, 0, 16, 32};
    rst = 1; start = 0; k_len = '0; bypass = 0; shift = 0; vld = 0; x = '0; w = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // scenario 1: K=3, skewed, strobe every 5th cycle
    fb = fed_total; db = done_total;
    run(3, 0, -1, -1, 5);
    chk("s1 fed strobes", 64'(fed_total - fb), 6);
    chk("s1 done pulses", 64'(done_total - db), 1);
    chk("s1 done after last strobe", 64'(done_cyc - last_fv_cyc), 1);
    for (int k = 0; k < 6; k++) chk_q($sformatf("s1 lane2 strobe %0d", k), q_l2, fb + k, e1[k]);

    // scenario 2: bubble on strobe 1
    fb = fed_total; ab = dacc_total;
    run(3, 0, 1, -1, 5);
    chk("s2 fed strobes", 64'(fed_total - fb), 7);
    chk("s2 accepts", 64'(dacc_total - ab), 3);
    for (int k = 0; k < 4; k++) chk_q($sformatf("s2 lane0 strobe %0d", k), q_l0, fb + k, e2[k]);

    // scenario 3: bypass, K=2
    fb = fed_total; db = done_total;
    run(2, 1, -1, -1, 5);
    chk("s3 fed strobes", 64'(fed_total - fb), 2);
    chk("s3 done pulses", 64'(done_total - db), 1);
    chk("s3 no drain", 64'(done_cyc - last_fv_cyc), 1);
    chk_q("s3 lane3 strobe 0", q_l3, fb, 3);
    chk_q("s3 lane3 strobe 1", q_l3, fb + 1, 19);

    // scenario 4: K=0
    fb = fed_total; rb = rdy_total;
    run(0, 0, -1, -1, 5);
    chk("s4 done latency", 64'(done_cyc - start_cyc), 1);
    chk("s4 fed strobes", 64'(fed_total - fb), 0);
    chk("s4 rdy cycles", 64'(rdy_total - rb), 0);

    // scenario 5: async reset mid-LOAD, then a clean rerun of scenario 1
    db = done_total;
    @(posedge clk); #1;
    start = 1; k_len = 3; bypass = 0; vld = 1; shift = 0; drive(0);
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 10; c++) begin
      shift = (c % 5 == 4); drive(m_acc);
      @(posedge clk); #1;
    end
    shift = 1; drive(m_acc);
    #1;
    chk("s5 feeding before reset", 64'(fv), 1);
    rst = 1;
    #1;
    chk("s5 async O_X", ox, 0); chk("s5 async O_W", ow, 0);
    chk("s5 async O_FEED_VLD", 64'(fv), 0); chk("s5 async O_RDY", 64'(rdy), 0);
    chk("s5 async O_BUSY", 64'(busy), 0); chk("s5 async O_DONE", 64'(done), 0);
    @(negedge clk); @(posedge clk); #1;
    rst = 0; shift = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("s5 no done after abort", 64'(done_total - db), 0);
    fb = fed_total;
    run(3, 0, -1, -1, 5);
    chk("s5 rerun fed strobes", 64'(fed_total - fb), 6);
    for (int k = 0; k < 6; k++) chk_q($sformatf("s5 lane2 strobe %0d", k), q_l2, fb + k, e1[k]);

    // scenario 6: start re-pulsed in DRAIN (strobe 4) with K_LEN=7
    fb = fed_total; db = done_total;
    run(3, 0, -1, 4, 5);
    chk("s6 fed strobes", 64'(fed_total - fb), 6);
    chk("s6 done pulses", 64'(done_total - db), 1);
    for (int k = 0; k < 6; k++) chk_q($sformatf("s6 lane2 strobe %0d", k), q_l2, fb + k, e1[k]);

    // scenario 7: K_LEN above K_MAX saturates, strobe every cycle
    fb = fed_total;
    run(300, 0, -1, -1, 1);
    chk("s7 saturated fed strobes", 64'(fed_total - fb), 259);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
